// File: rtl/vip_proj_pkg.sv
// Shared definitions for the horizontal and vertical projection stages:
// counter width, the frame-scan state type and a saturating adder.
package vip_proj_pkg;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } proj_state_e;

  // Counters in the projection stages must never wrap back into range.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/vip_horizontal_projection_if.sv
// Video in/out, column window and per-frame result bundle of the
// horizontal projection stage.  master = video source / result consumer,
// slave = the projection block.
interface vip_horizontal_projection_if;
  import vip_proj_pkg::*;

  logic             per_frame_vsync;
  logic             per_frame_href;
  logic             per_frame_clken;
  logic             per_img_Bit;
  logic [CNT_W-1:0] horizontal_start;
  logic [CNT_W-1:0] horizontal_end;

  logic             post_frame_vsync;
  logic             post_frame_href;
  logic             post_frame_clken;
  logic             post_img_Bit;
  logic [CNT_W-1:0] max_line_up;
  logic [CNT_W-1:0] max_line_down;
  logic             plate_found;
  logic             result_valid;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
    output horizontal_start, horizontal_end,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
    input  max_line_up, max_line_down, plate_found, result_valid
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
    input  horizontal_start, horizontal_end,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
    output max_line_up, max_line_down, plate_found, result_valid
  );

endinterface

// File: rtl/vip_frame_sync_delay.sv
// Two-stage delay of the binarized video signals.  Exposes the first stage
// for pixel accumulation, the second stage as the pass-through video, and
// the frame/line edge flags derived from the two stages.
module vip_frame_sync_delay (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  input  logic href_i,
  input  logic clken_i,
  input  logic bit_i,
  output logic s1_href_o,
  output logic s1_clken_o,
  output logic s1_bit_o,
  output logic s2_vsync_o,
  output logic s2_href_o,
  output logic s2_clken_o,
  output logic s2_bit_o,
  output logic vs_rise_o,
  output logic vs_fall_o,
  output logic hs_fall_o
);

  localparam int VS = 3;
  localparam int HS = 2;
  localparam int CE = 1;
  localparam int PX = 0;

  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;

  assign s1_d = {vsync_i, href_i, clken_i, bit_i};
  assign s2_d = s1_q;

  // Shift the video bundle through both stages every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1_href_o  = s1_q[HS];
  assign s1_clken_o = s1_q[CE];
  assign s1_bit_o   = s1_q[PX];

  assign s2_vsync_o = s2_q[VS];
  assign s2_href_o  = s2_q[HS];
  assign s2_clken_o = s2_q[CE];
  assign s2_bit_o   = s2_q[PX];

  // s1 holds the newer sample, so a 0 in s1 over a 1 in s2 is a falling edge.
  assign vs_fall_o = !s1_q[VS] &&  s2_q[VS];
  assign vs_rise_o =  s1_q[VS] && !s2_q[VS];
  assign hs_fall_o = !s1_q[HS] &&  s2_q[HS];

endmodule

// File: rtl/vip_horizontal_projection.sv
// Horizontal projection: counts foreground pixels per row inside a column
// window and reports the first and last rows whose count exceeds
// ROW_THRESH, once per frame.  Video passes through with two cycles delay.
//
//   state | meaning
//   IDLE  | between frames, or after reset until a full frame starts
//   SCAN  | inside a frame, rows being evaluated
module vip_horizontal_projection
  import vip_proj_pkg::*;
#(
  parameter logic [CNT_W-1:0] IMG_HDISP  = 10'd640,
  parameter logic [CNT_W-1:0] IMG_VDISP  = 10'd480,
  parameter logic [CNT_W-1:0] ROW_THRESH = 10'd30
) (
  input logic clk,
  input logic rst,
  vip_horizontal_projection_if.slave bus
);

  logic s1_href, s1_clken, s1_bit;
  logic s2_vsync, s2_href, s2_clken, s2_bit;
  logic vs_rise, vs_fall, hs_fall;

  vip_frame_sync_delay u_sync (
    .clk        (clk),
    .rst        (rst),
    .vsync_i    (bus.per_frame_vsync),
    .href_i     (bus.per_frame_href),
    .clken_i    (bus.per_frame_clken),
    .bit_i      (bus.per_img_Bit),
    .s1_href_o  (s1_href),
    .s1_clken_o (s1_clken),
    .s1_bit_o   (s1_bit),
    .s2_vsync_o (s2_vsync),
    .s2_href_o  (s2_href),
    .s2_clken_o (s2_clken),
    .s2_bit_o   (s2_bit),
    .vs_rise_o  (vs_rise),
    .vs_fall_o  (vs_fall),
    .hs_fall_o  (hs_fall)
  );

  assign bus.post_frame_vsync = s2_vsync;
  assign bus.post_frame_href  = s2_href;
  assign bus.post_frame_clken = s2_clken;
  assign bus.post_img_Bit     = s2_bit;

  logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
  logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
  logic [CNT_W-1:0] row_sum_q, row_sum_d;
  logic             in_window;

  // Exclusive bounds on both sides; a start >= end window is simply empty.
  // Pixels beyond the nominal line width never contribute.
  assign in_window = (bus.horizontal_start < x_cnt_q) &&
                     (x_cnt_q < bus.horizontal_end) &&
                     (x_cnt_q < IMG_HDISP);

  // Column/row position and the per-row foreground count.
  always_comb begin
    x_cnt_d   = x_cnt_q;
    y_cnt_d   = y_cnt_q;
    row_sum_d = row_sum_q;

    if (vs_fall || hs_fall) begin
      x_cnt_d = '0;
    end else if (s1_clken) begin
      x_cnt_d = sat_add(x_cnt_q, CNT_W'(1));
    end

    if (vs_fall) begin
      y_cnt_d = '0;
    end else if (hs_fall) begin
      y_cnt_d = sat_add(y_cnt_q, CNT_W'(1));
    end

    if (vs_fall || hs_fall) begin
      row_sum_d = '0;
    end else if (s1_clken && s1_href && in_window) begin
      row_sum_d = sat_add(row_sum_q, CNT_W'(s1_bit));
    end
  end

  // Register the position counters and row accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
      row_sum_q <= '0;
    end else begin
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
      row_sum_q <= row_sum_d;
    end
  end

  proj_state_e      state_q, state_d;
  logic             found_q, found_d;
  logic [CNT_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] bottom_q, bottom_d;
  logic [CNT_W-1:0] line_up_q, line_up_d;
  logic [CNT_W-1:0] line_down_q, line_down_d;
  logic             plate_q, plate_d;
  logic             valid_q, valid_d;
  logic             row_hit;

  // A row qualifies only while still inside the active frame height.
  assign row_hit = (y_cnt_q < IMG_VDISP) && (row_sum_q > ROW_THRESH);

  // Frame-scan FSM: tracks the first/last qualifying rows and publishes
  // them at frame end.  A frame start always wins over a coincident row end.
  always_comb begin
    state_d     = state_q;
    found_d     = found_q;
    top_d       = top_q;
    bottom_d    = bottom_q;
    line_up_d   = line_up_q;
    line_down_d = line_down_q;
    plate_d     = plate_q;
    valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (vs_fall) begin
          state_d  = SCAN;
          found_d  = 1'b0;
          top_d    = '0;
          bottom_d = '0;
        end
      end
      SCAN: begin
        if (vs_rise) begin
          state_d     = IDLE;
          line_up_d   = top_q;
          line_down_d = bottom_q;
          plate_d     = found_q;
          valid_d     = 1'b1;
        end else if (vs_fall) begin
          found_d  = 1'b0;
          top_d    = '0;
          bottom_d = '0;
        end else if (hs_fall && row_hit) begin
          bottom_d = y_cnt_q;
          if (!found_q) begin
            top_d   = y_cnt_q;
            found_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      found_q     <= 1'b0;
      top_q       <= '0;
      bottom_q    <= '0;
      line_up_q   <= '0;
      line_down_q <= '0;
      plate_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      found_q     <= found_d;
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      line_up_q   <= line_up_d;
      line_down_q <= line_down_d;
      plate_q     <= plate_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.max_line_up   = line_up_q;
  assign bus.max_line_down = line_down_q;
  assign bus.plate_found   = plate_q;
  assign bus.result_valid  = valid_q;

endmodule

// File: tb/tb_vip_horizontal_projection.sv
// Bench for vip_horizontal_projection on a 16x12 image with threshold 3.
module tb_vip_horizontal_projection;
  import vip_proj_pkg::*;

  localparam int HD = 16;
  localparam int VD = 12;
  localparam int TH = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vip_horizontal_projection_if bus();

  vip_horizontal_projection #(
    .IMG_HDISP  (10'd16),
    .IMG_VDISP  (10'd12),
    .ROW_THRESH (10'd3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pass-through monitor: post_* must equal the inputs sampled two edges ago.
  logic [3:0] hist1, hist2;
  int vcnt = 0;
  always @(posedge clk) begin
    hist2 <= hist1;
    hist1 <= {bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken, bus.per_img_Bit};
    if (rst) vcnt <= 0;
    else if (vcnt < 2) vcnt <= vcnt + 1;
  end
  always @(negedge clk) begin
    if (vcnt == 2 && !rst)
      check("post_delay2",
            32'({bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken, bus.post_img_Bit}),
            32'(hist2));
  end

  int pulses = 0;
  int exp_pulses = 0;
  always @(negedge clk) if (bus.result_valid === 1'b1) pulses++;

  logic [HD-1:0] img [VD];
  int win_s, win_e;
  int m_up, m_down, m_found;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_img();
    for (int r = 0; r < VD; r++) img[r] = '0;
  endtask

  // Reference: per-row count of foreground pixels at columns strictly
  // between the window bounds, first/last row with count > TH.
  task automatic model();
    m_up = 0; m_down = 0; m_found = 0;
    for (int r = 0; r < VD; r++) begin
      int cnt = 0;
      for (int c = 0; c < HD; c++)
        if (win_s < c && c < win_e && img[r][c]) cnt++;
      if (cnt > TH) begin
        if (m_found == 0) m_up = r;
        m_found = 1;
        m_down = r;
      end
    end
  endtask

  // Drive one frame; rst_row >= 0 pulses reset for two cycles inside that row.
  task automatic run_frame(input string tag, input int rst_row, input logic exp_pulse,
                           input int eu, input int ed, input int ef);
    bus.horizontal_start = 10'(win_s);
    bus.horizontal_end   = 10'(win_e);
    bus.per_frame_vsync = 1'b1; bus.per_frame_href = 1'b0;
    bus.per_frame_clken = 1'b0; bus.per_img_Bit = 1'b0;
    repeat (3) step();
    bus.per_frame_vsync = 1'b0;
    repeat (3) step();
    for (int r = 0; r < VD; r++) begin
      int c = 0;
      int k = 0;
      while (c < HD) begin
        bus.per_frame_href = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          bus.per_frame_clken = 1'b0;
          bus.per_img_Bit = 1'($urandom);
        end else begin
          bus.per_frame_clken = 1'b1;
          bus.per_img_Bit = img[r][c];
          c++;
        end
        rst = (r == rst_row) && (k == 3 || k == 4);
        k++;
        step();
      end
      rst = 1'b0;
      bus.per_frame_href = 1'b0; bus.per_frame_clken = 1'b0;
      bus.per_img_Bit = 1'($urandom);
      repeat (4) step();
    end
    bus.per_frame_vsync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_rv_early"}, 32'(bus.result_valid), 32'(0));
    @(negedge clk);
    check({tag, "_rv"}, 32'(bus.result_valid), 32'(exp_pulse));
    check({tag, "_up"}, 32'(bus.max_line_up), 32'(eu));
    check({tag, "_down"}, 32'(bus.max_line_down), 32'(ed));
    check({tag, "_found"}, 32'(bus.plate_found), 32'(ef));
    if (exp_pulse) exp_pulses++;
    @(negedge clk);
    check({tag, "_rv_off"}, 32'(bus.result_valid), 32'(0));
    repeat (2) @(negedge clk);
    check({tag, "_up_hold"}, 32'(bus.max_line_up), 32'(eu));
    check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    rst = 1'b1;
    bus.per_frame_vsync = 1'b0; bus.per_frame_href = 1'b0;
    bus.per_frame_clken = 1'b0; bus.per_img_Bit = 1'b0;
    bus.horizontal_start = '0; bus.horizontal_end = 10'd15;
    win_s = 0; win_e = 15;
    repeat (3) step();
    @(negedge clk);
    check("rst_up", 32'(bus.max_line_up), 32'(0));
    check("rst_down", 32'(bus.max_line_down), 32'(0));
    check("rst_found", 32'(bus.plate_found), 32'(0));
    check("rst_rv", 32'(bus.result_valid), 32'(0));
    check("rst_post", 32'({bus.post_frame_vsync, bus.post_frame_href,
                           bus.post_frame_clken, bus.post_img_Bit}), 32'(0));
    rst = 1'b0;
    step();

    // Rows 4..7 with 8 ones inside the window.
    clear_img();
    for (int r = 4; r <= 7; r++) img[r] = 16'h07F8;
    run_frame("band", -1, 1'b1, 4, 7, 1);

    // Empty frame still publishes.
    clear_img();
    run_frame("zero", -1, 1'b1, 0, 0, 0);

    // Threshold is strict: 3 ones does not qualify, 4 does.
    clear_img();
    img[5] = 16'h000E;
    img[6] = 16'h001E;
    run_frame("thresh", -1, 1'b1, 6, 6, 1);

    // Window 4..9: only columns 5..8 count.
    win_s = 4; win_e = 9;
    clear_img();
    img[2] = 16'hFE1F;
    run_frame("win_out", -1, 1'b1, 0, 0, 0);
    clear_img();
    img[2] = 16'h01E0;
    run_frame("win_in", -1, 1'b1, 2, 2, 1);

    // Inverted window is empty.
    win_s = 9; win_e = 4;
    for (int r = 0; r < VD; r++) img[r] = 16'hFFFF;
    run_frame("win_empty", -1, 1'b1, 0, 0, 0);

    // Reset inside row 6: frame discarded, outputs at reset values.
    win_s = 0; win_e = 15;
    clear_img();
    for (int r = 4; r <= 7; r++) img[r] = 16'h07F8;
    run_frame("rst_mid", 6, 1'b0, 0, 0, 0);
    run_frame("after_rst", -1, 1'b1, 4, 7, 1);

    // Random images and windows against the reference model.
    for (int f = 0; f < 8; f++) begin
      win_s = $urandom_range(0, 8);
      win_e = $urandom_range(4, 15);
      for (int r = 0; r < VD; r++)
        img[r] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom & $urandom);
      model();
      run_frame("rand", -1, 1'b1, m_up, m_down, m_found);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
